// File: rtl/onehot_decoder_seq.sv
// -----------------------------------------------------------------------------
// onehot_decoder_seq
//   Registered binary-to-one-hot (or one-cold) decoder with a clocked select
//   register. The select can be loaded directly through a valid/ready port,
//   scanned up or down with a programmable dwell, or frozen. A one-cycle wrap
//   pulse marks scan wrap-around. Typical use is as a row/bank/LED strobe
//   generator.
//
// Parameters
//   SEL_W       select width; OUT_W = 2**SEL_W outputs
//   STEP_DIV    clock cycles each select is held while scanning (>= 1)
//   ACTIVE_LOW  0: asserted bit = 1, idle = 0; 1: asserted bit = 0, idle = 1
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   en        in   block enable; 0 drives out to the idle pattern
//   mode      in   00 DIRECT, 01 SCAN_UP, 10 SCAN_DOWN, 11 HOLD
//   in_valid  in   in_sel is valid (load request in DIRECT mode)
//   in_sel    in   select value to load
//   in_ready  out  combinational, en & (mode == DIRECT)
//   out       out  registered decode of cur_sel (idle pattern when disabled)
//   cur_sel   out  registered current select
//   wrap      out  registered one-cycle pulse on scan wrap-around
// -----------------------------------------------------------------------------
module onehot_decoder_seq #(
    parameter int SEL_W      = 3,
    parameter int STEP_DIV   = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [1:0]              mode,
    input  logic                    in_valid,
    input  logic [SEL_W-1:0]        in_sel,
    output logic                    in_ready,
    output logic [(1<<SEL_W)-1:0]   out,
    output logic [SEL_W-1:0]        cur_sel,
    output logic                    wrap
);

    localparam int OUT_W = 1 << SEL_W;
    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_DIV - 1);
    localparam logic [OUT_W-1:0] IDLE_PAT = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
    localparam logic [SEL_W-1:0] SEL_MAX = {SEL_W{1'b1}};
    localparam logic [SEL_W-1:0] SEL_MIN = {SEL_W{1'b0}};

    typedef enum logic [1:0] {
        MODE_DIRECT    = 2'b00,
        MODE_SCAN_UP   = 2'b01,
        MODE_SCAN_DOWN = 2'b10,
        MODE_HOLD      = 2'b11
    } mode_e;

    // Plain one-hot decode; polarity is applied separately.
    function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] s);
        logic [OUT_W-1:0] v;
        v    = {OUT_W{1'b0}};
        v[s] = 1'b1;
        return v;
    endfunction

    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_eff_s;
    mode_e            mode_q;
    mode_e            mode_s;
    logic             wrap_q, wrap_d;
    logic [OUT_W-1:0] out_q, out_d;

    assign mode_s   = mode_e'(mode);
    assign in_ready = en & (mode_s == MODE_DIRECT);
    assign out      = out_q;
    assign cur_sel  = sel_q;
    assign wrap     = wrap_q;

    // Next-state: select load/scan, dwell counter, wrap pulse and output decode.
    always_comb begin
        sel_d  = sel_q;
        cnt_d  = {CNT_W{1'b0}};
        wrap_d = 1'b0;
        // Any mode change restarts the dwell: the change edge counts as the
        // first cycle of a fresh dwell on the preserved select.
        if (mode_s != mode_q) begin
            cnt_eff_s = {CNT_W{1'b0}};
        end else begin
            cnt_eff_s = cnt_q;
        end
        if (en) begin
            case (mode_s)
                MODE_DIRECT: begin
                    if (in_valid) begin
                        sel_d = in_sel;
                    end else begin
                        sel_d = sel_q;
                    end
                end
                MODE_SCAN_UP: begin
                    if (cnt_eff_s == CNT_MAX) begin
                        sel_d  = sel_q + SEL_W'(1);
                        wrap_d = (sel_q == SEL_MAX);
                    end else begin
                        cnt_d = cnt_eff_s + CNT_W'(1);
                    end
                end
                MODE_SCAN_DOWN: begin
                    if (cnt_eff_s == CNT_MAX) begin
                        sel_d  = sel_q - SEL_W'(1);
                        wrap_d = (sel_q == SEL_MIN);
                    end else begin
                        cnt_d = cnt_eff_s + CNT_W'(1);
                    end
                end
                MODE_HOLD: begin
                    sel_d = sel_q;
                end
                default: begin
                    sel_d = sel_q;
                end
            endcase
        end else begin
            sel_d = sel_q;
        end
        // Decode from the next select so out and cur_sel always agree.
        if (en) begin
            out_d = decode(sel_d) ^ IDLE_PAT;
        end else begin
            out_d = IDLE_PAT;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q  <= {SEL_W{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
            mode_q <= MODE_DIRECT;
            wrap_q <= 1'b0;
            out_q  <= IDLE_PAT;
        end else begin
            sel_q  <= sel_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_s;
            wrap_q <= wrap_d;
            out_q  <= out_d;
        end
    end

endmodule
